// File: rtl/jzjpcc_mem_load_processor.sv
// Memory-stage load path: registers load control from execute, holds the RAM word
// across stalls and extracts/extends the addressed byte, halfword or word.
module jzjpcc_mem_load_processor #(
  parameter logic [31:0] RESET_VALUE = 32'h00000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        memoryLoad_execute,
  input  logic [2:0]  funct3_execute,
  input  logic [31:0] aluResult_execute,
  input  logic [4:0]  rd_execute,
  input  logic        stall_memory,
  input  logic        flush_memory,
  input  logic [31:0] memDataRead_memory,
  output logic [31:0] loadResult_memory,
  output logic        loadValid_memory,
  output logic [4:0]  rd_memory,
  output logic        loadMisaligned_memory,
  output logic        loadIllegal_memory
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic        valid_q, valid_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  offset_q, offset_d;
  logic [4:0]  rd_q, rd_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_word_q, hold_word_d;

  logic [31:0] word_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] result_s;
  logic        misaligned_s;
  logic        illegal_s;

  // Next-state for the stage register: flush beats stall beats advance.
  always_comb begin
    valid_d      = valid_q;
    funct3_d     = funct3_q;
    offset_d     = offset_q;
    rd_d         = rd_q;
    hold_valid_d = hold_valid_q;
    hold_word_d  = hold_word_q;
    if (flush_memory) begin
      valid_d      = 1'b0;
      hold_valid_d = 1'b0;
    end else if (stall_memory) begin
      if (!hold_valid_q) begin
        hold_word_d  = memDataRead_memory;
        hold_valid_d = 1'b1;
      end else begin
        hold_word_d  = hold_word_q;
      end
    end else begin
      valid_d      = memoryLoad_execute;
      funct3_d     = funct3_execute;
      offset_d     = aluResult_execute[1:0];
      rd_d         = rd_execute;
      hold_valid_d = 1'b0;
    end
  end

  // Stage and hold registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      funct3_q     <= 3'b000;
      offset_q     <= 2'b00;
      rd_q         <= 5'd0;
      hold_valid_q <= 1'b0;
      hold_word_q  <= 32'h00000000;
    end else begin
      valid_q      <= valid_d;
      funct3_q     <= funct3_d;
      offset_q     <= offset_d;
      rd_q         <= rd_d;
      hold_valid_q <= hold_valid_d;
      hold_word_q  <= hold_word_d;
    end
  end

  // Little-endian lane selection from the RAM word or the held copy.
  always_comb begin
    word_s = hold_valid_q ? hold_word_q : memDataRead_memory;
    case (offset_q)
      2'd0:    byte_s = word_s[7:0];
      2'd1:    byte_s = word_s[15:8];
      2'd2:    byte_s = word_s[23:16];
      2'd3:    byte_s = word_s[31:24];
      default: byte_s = word_s[7:0];
    endcase
    if (offset_q[1]) begin
      half_s = word_s[31:16];
    end else begin
      half_s = word_s[15:0];
    end
  end

  // Extension, alignment and legality; faulting loads return zero.
  always_comb begin
    result_s     = 32'h00000000;
    misaligned_s = 1'b0;
    illegal_s    = 1'b0;
    case (funct3_q)
      F3_LB:  result_s = {{24{byte_s[7]}}, byte_s};
      F3_LBU: result_s = {24'h000000, byte_s};
      F3_LH, F3_LHU: begin
        if (offset_q[0]) begin
          misaligned_s = 1'b1;
        end else if (funct3_q == F3_LH) begin
          result_s = {{16{half_s[15]}}, half_s};
        end else begin
          result_s = {16'h0000, half_s};
        end
      end
      F3_LW: begin
        if (offset_q != 2'd0) begin
          misaligned_s = 1'b1;
        end else begin
          result_s = word_s;
        end
      end
      default: illegal_s = 1'b1;
    endcase
  end

  assign loadResult_memory     = valid_q ? result_s : RESET_VALUE;
  assign loadValid_memory      = valid_q;
  assign rd_memory             = rd_q;
  assign loadMisaligned_memory = valid_q & misaligned_s;
  assign loadIllegal_memory    = valid_q & illegal_s;

endmodule

// File: tb/tb_jzjpcc_mem_load_processor.sv
// Self-checking bench for jzjpcc_mem_load_processor: vector table plus stall,
// flush and reset sequences, with a queue of expected outputs.
module tb_jzjpcc_mem_load_processor;

  logic        clock = 1'b0;
  logic        reset;
  logic        memoryLoad_execute;
  logic [2:0]  funct3_execute;
  logic [31:0] aluResult_execute;
  logic [4:0]  rd_execute;
  logic        stall_memory;
  logic        flush_memory;
  logic [31:0] memDataRead_memory;
  logic [31:0] loadResult_memory;
  logic        loadValid_memory;
  logic [4:0]  rd_memory;
  logic        loadMisaligned_memory;
  logic        loadIllegal_memory;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] result;
    logic        valid;
    logic [4:0]  rd;
    logic        mis;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [4:0]  rd;
    logic [31:0] ram;
    logic [31:0] result;
    logic        mis;
    logic        ill;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  jzjpcc_mem_load_processor #(.RESET_VALUE(32'h00000000)) dut (
    .clock(clock), .reset(reset),
    .memoryLoad_execute(memoryLoad_execute), .funct3_execute(funct3_execute),
    .aluResult_execute(aluResult_execute), .rd_execute(rd_execute),
    .stall_memory(stall_memory), .flush_memory(flush_memory),
    .memDataRead_memory(memDataRead_memory), .loadResult_memory(loadResult_memory),
    .loadValid_memory(loadValid_memory), .rd_memory(rd_memory),
    .loadMisaligned_memory(loadMisaligned_memory), .loadIllegal_memory(loadIllegal_memory)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] r, input logic v, input logic [4:0] rd,
                          input logic m, input logic i);
    exp_t e;
    e.result = r; e.valid = v; e.rd = rd; e.mis = m; e.ill = i;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty, got result %h", tag, loadResult_memory);
    end else begin
      e = sb.pop_front();
      chk({tag, ".result"}, loadResult_memory, e.result);
      chk({tag, ".valid"},  {31'd0, loadValid_memory}, {31'd0, e.valid});
      chk({tag, ".rd"},     {27'd0, rd_memory}, {27'd0, e.rd});
      chk({tag, ".mis"},    {31'd0, loadMisaligned_memory}, {31'd0, e.mis});
      chk({tag, ".ill"},    {31'd0, loadIllegal_memory}, {31'd0, e.ill});
    end
  endtask

  task automatic drive_exec(input logic ld, input logic [2:0] f3, input logic [1:0] off,
                            input logic [4:0] rd);
    memoryLoad_execute = ld;
    funct3_execute     = f3;
    aluResult_execute  = {28'h1000000, 2'b00, off};
    rd_execute         = rd;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic add_vec(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd,
                         input logic [31:0] ram, input logic [31:0] res, input logic m,
                         input logic i);
    vec_t v;
    v.f3 = f3; v.off = off; v.rd = rd; v.ram = ram; v.result = res; v.mis = m; v.ill = i;
    vecs.push_back(v);
  endtask

  initial begin
    add_vec(3'b000, 2'd0, 5'd1,  32'h80FF7F01, 32'h00000001, 1'b0, 1'b0);
    add_vec(3'b000, 2'd1, 5'd2,  32'h80FF7F01, 32'h0000007F, 1'b0, 1'b0);
    add_vec(3'b000, 2'd2, 5'd3,  32'h80FF7F01, 32'hFFFFFFFF, 1'b0, 1'b0);
    add_vec(3'b000, 2'd3, 5'd4,  32'h80FF7F01, 32'hFFFFFF80, 1'b0, 1'b0);
    add_vec(3'b100, 2'd3, 5'd5,  32'h80FF7F01, 32'h00000080, 1'b0, 1'b0);
    add_vec(3'b001, 2'd0, 5'd6,  32'h80FF7F01, 32'h00007F01, 1'b0, 1'b0);
    add_vec(3'b001, 2'd2, 5'd7,  32'h80FF7F01, 32'hFFFF80FF, 1'b0, 1'b0);
    add_vec(3'b101, 2'd2, 5'd8,  32'h80FF7F01, 32'h000080FF, 1'b0, 1'b0);
    add_vec(3'b001, 2'd1, 5'd9,  32'h80FF7F01, 32'h00000000, 1'b1, 1'b0);
    add_vec(3'b101, 2'd3, 5'd10, 32'h80FF7F01, 32'h00000000, 1'b1, 1'b0);
    add_vec(3'b010, 2'd0, 5'd11, 32'h80FF7F01, 32'h80FF7F01, 1'b0, 1'b0);
    add_vec(3'b010, 2'd2, 5'd12, 32'h80FF7F01, 32'h00000000, 1'b1, 1'b0);
    add_vec(3'b010, 2'd1, 5'd13, 32'h80FF7F01, 32'h00000000, 1'b1, 1'b0);
    add_vec(3'b011, 2'd0, 5'd14, 32'h80FF7F01, 32'h00000000, 1'b0, 1'b1);
    add_vec(3'b110, 2'd3, 5'd15, 32'h80FF7F01, 32'h00000000, 1'b0, 1'b1);
    add_vec(3'b100, 2'd1, 5'd16, 32'h12345678, 32'h00000056, 1'b0, 1'b0);
    add_vec(3'b101, 2'd0, 5'd17, 32'h12348765, 32'h00008765, 1'b0, 1'b0);

    reset = 1'b1;
    stall_memory = 1'b0;
    flush_memory = 1'b0;
    memDataRead_memory = 32'hA5A5A5A5;
    drive_exec(1'b1, 3'b010, 2'd0, 5'd31);
    tick;
    push_exp(32'h00000000, 1'b0, 5'd0, 1'b0, 1'b0);
    pop_chk("reset");
    tick;
    reset = 1'b0;

    // Vector table, one-cycle latency from execute to memory output.
    foreach (vecs[k]) begin
      drive_exec(1'b1, vecs[k].f3, vecs[k].off, vecs[k].rd);
      push_exp(vecs[k].result, 1'b1, vecs[k].rd, vecs[k].mis, vecs[k].ill);
      tick;
      drive_exec(1'b0, 3'b000, 2'd0, 5'd0);
      memDataRead_memory = vecs[k].ram;
      #1;
      pop_chk($sformatf("vec%0d", k));
    end

    // Idle stage: no valid load yet rd still shows the registered value.
    tick;
    push_exp(32'h00000000, 1'b0, 5'd0, 1'b0, 1'b0);
    pop_chk("idle");

    // Stall hold across three stalled edges while RAM output changes.
    drive_exec(1'b1, 3'b010, 2'd0, 5'd7);
    tick;
    memDataRead_memory = 32'hDEADBEEF;
    drive_exec(1'b1, 3'b100, 2'd1, 5'd3);
    stall_memory = 1'b1;
    #1;
    push_exp(32'hDEADBEEF, 1'b1, 5'd7, 1'b0, 1'b0);
    pop_chk("stall0");
    for (int s = 1; s <= 3; s++) begin
      tick;
      memDataRead_memory = 32'h12345678;
      #1;
      push_exp(32'hDEADBEEF, 1'b1, 5'd7, 1'b0, 1'b0);
      pop_chk($sformatf("stall%0d", s));
    end
    stall_memory = 1'b0;
    tick;
    drive_exec(1'b0, 3'b000, 2'd0, 5'd0);
    #1;
    push_exp(32'h00000056, 1'b1, 5'd3, 1'b0, 1'b0);
    pop_chk("release");

    // Flush of a valid load.
    drive_exec(1'b1, 3'b010, 2'd0, 5'd9);
    tick;
    drive_exec(1'b1, 3'b010, 2'd0, 5'd20);
    memDataRead_memory = 32'hCAFEF00D;
    #1;
    push_exp(32'hCAFEF00D, 1'b1, 5'd9, 1'b0, 1'b0);
    pop_chk("preflush");
    flush_memory = 1'b1;
    tick;
    flush_memory = 1'b0;
    drive_exec(1'b0, 3'b000, 2'd0, 5'd0);
    push_exp(32'h00000000, 1'b0, 5'd9, 1'b0, 1'b0);
    pop_chk("flush");

    // Flush together with stall while a word is held.
    drive_exec(1'b1, 3'b010, 2'd0, 5'd10);
    tick;
    drive_exec(1'b0, 3'b000, 2'd0, 5'd0);
    memDataRead_memory = 32'hAAAA5555;
    stall_memory = 1'b1;
    tick;
    memDataRead_memory = 32'h11112222;
    #1;
    push_exp(32'hAAAA5555, 1'b1, 5'd10, 1'b0, 1'b0);
    pop_chk("held");
    flush_memory = 1'b1;
    tick;
    flush_memory = 1'b0;
    stall_memory = 1'b0;
    push_exp(32'h00000000, 1'b0, 5'd10, 1'b0, 1'b0);
    pop_chk("flushstall");
    drive_exec(1'b1, 3'b010, 2'd0, 5'd11);
    tick;
    drive_exec(1'b0, 3'b000, 2'd0, 5'd0);
    memDataRead_memory = 32'h33334444;
    #1;
    push_exp(32'h33334444, 1'b1, 5'd11, 1'b0, 1'b0);
    pop_chk("afterflush");

    // Asynchronous reset in the middle of a stall.
    drive_exec(1'b1, 3'b010, 2'd0, 5'd12);
    tick;
    drive_exec(1'b0, 3'b000, 2'd0, 5'd0);
    memDataRead_memory = 32'h55667788;
    stall_memory = 1'b1;
    tick;
    #2;
    reset = 1'b1;
    #1;
    push_exp(32'h00000000, 1'b0, 5'd0, 1'b0, 1'b0);
    pop_chk("asyncreset");
    tick;
    reset = 1'b0;
    stall_memory = 1'b0;
    memDataRead_memory = 32'h80FF7F01;
    drive_exec(1'b1, 3'b000, 2'd3, 5'd21);
    tick;
    drive_exec(1'b0, 3'b000, 2'd0, 5'd0);
    #1;
    push_exp(32'hFFFFFF80, 1'b1, 5'd21, 1'b0, 1'b0);
    pop_chk("postreset");

    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL leftover: %0d entries, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
